// File: rtl/ladybird_aclint.sv
// Single-hart ACLINT (MSWI + MTIMER + SSWI) register block on the uncached D_BUS path.
// One outstanding request; read data is captured at acceptance and held until consumed.
module ladybird_aclint #(
  parameter logic [31:0] BASEADDR = 32'h0200_0000,
  parameter int          TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        msip_o,
  output logic        mtip_o,
  output logic        ssip_o
);

  // state  | meaning
  // S_IDLE | ready to accept a request
  // S_RESP | response valid, waiting for resp_ready
  typedef enum logic {S_IDLE, S_RESP} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic [63:0]   r_mtimecmp;
  logic          r_msip;
  logic          r_ssip;
  logic          r_mtip;
  logic [31:0]   r_resp_data;

  logic          w_accept;
  logic          w_wr;
  logic          w_hit;
  logic [13:0]   w_off;
  logic          w_sel_msip;
  logic          w_sel_cmp_lo;
  logic          w_sel_cmp_hi;
  logic          w_sel_setssip;
  logic          w_sel_mt_lo;
  logic          w_sel_mt_hi;
  logic          w_tick;
  logic [63:0]   w_mtime_inc;
  logic [63:0]   w_mtime_nxt;
  logic [63:0]   w_mtimecmp_nxt;
  logic [31:0]   w_rdata;
  logic          w_unused;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_unused = &{1'b0, req_addr[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid)  w_state_nxt = S_RESP;
      S_RESP:  if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign msip_o     = r_msip;
  assign mtip_o     = r_mtip;
  assign ssip_o     = r_ssip;

  assign w_accept      = req_valid & req_ready;
  assign w_wr          = w_accept & (|req_wstrb);
  assign w_hit         = (req_addr[31:16] == BASEADDR[31:16]);
  assign w_off         = req_addr[15:2];
  assign w_sel_msip    = w_hit & (w_off == 14'h0000);
  assign w_sel_cmp_lo  = w_hit & (w_off == 14'h1000);
  assign w_sel_cmp_hi  = w_hit & (w_off == 14'h1001);
  assign w_sel_setssip = w_hit & (w_off == 14'h2000);
  assign w_sel_mt_lo   = w_hit & (w_off == 14'h2FFE);
  assign w_sel_mt_hi   = w_hit & (w_off == 14'h2FFF);

  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_mtime_inc = r_mtime + {63'd0, w_tick};

  // Written bytes override the incremented value; the other half still sees the carry.
  always_comb begin
    w_mtime_nxt    = w_mtime_inc;
    w_mtimecmp_nxt = r_mtimecmp;
    if (w_wr && w_sel_mt_lo)
      w_mtime_nxt[31:0] = merge(w_mtime_inc[31:0], req_wdata, req_wstrb);
    if (w_wr && w_sel_mt_hi)
      w_mtime_nxt[63:32] = merge(w_mtime_inc[63:32], req_wdata, req_wstrb);
    if (w_wr && w_sel_cmp_lo)
      w_mtimecmp_nxt[31:0] = merge(r_mtimecmp[31:0], req_wdata, req_wstrb);
    if (w_wr && w_sel_cmp_hi)
      w_mtimecmp_nxt[63:32] = merge(r_mtimecmp[63:32], req_wdata, req_wstrb);
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel_msip)   w_rdata = {31'd0, r_msip};
    if (w_sel_cmp_lo) w_rdata = r_mtimecmp[31:0];
    if (w_sel_cmp_hi) w_rdata = r_mtimecmp[63:32];
    if (w_sel_mt_lo)  w_rdata = r_mtime[31:0];
    if (w_sel_mt_hi)  w_rdata = r_mtime[63:32];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc     <= '0;
      r_mtime     <= 64'd0;
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip      <= 1'b0;
      r_ssip      <= 1'b0;
      r_mtip      <= 1'b0;
      r_resp_data <= 32'd0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + 1'b1;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      // Compare on next-state values so a compare write shows up one cycle after acceptance.
      r_mtip     <= (w_mtime_nxt >= w_mtimecmp_nxt);
      r_ssip     <= w_wr & w_sel_setssip & req_wstrb[0] & req_wdata[0];
      if (w_wr && w_sel_msip && req_wstrb[0]) r_msip <= req_wdata[0];
      if (w_accept) r_resp_data <= w_wr ? 32'd0 : w_rdata;
    end
  end

endmodule

// File: tb/tb_ladybird_aclint.sv
// Directed bench for ladybird_aclint: table of register accesses plus hand sequences
// for timer wrap, compare timing, backpressure and mid-response reset.
module tb_ladybird_aclint;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        msip_o, mtip_o, ssip_o;

  localparam logic [31:0] B        = 32'h0200_0000;
  localparam logic [31:0] A_MSIP   = B + 32'h0000;
  localparam logic [31:0] A_CMPLO  = B + 32'h4000;
  localparam logic [31:0] A_CMPHI  = B + 32'h4004;
  localparam logic [31:0] A_SSIP   = B + 32'h8000;
  localparam logic [31:0] A_MTLO   = B + 32'hBFF8;
  localparam logic [31:0] A_MTHI   = B + 32'hBFFC;

  ladybird_aclint #(.BASEADDR(32'h0200_0000), .TICK_DIV(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .msip_o(msip_o), .mtip_o(mtip_o), .ssip_o(ssip_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // mtime model: value m_val after posedge number m_edge, +1 per edge
  logic [63:0] m_val = 64'd0;
  int          m_edge = 0;

  function automatic logic [63:0] mt_now(input int acc);
    return m_val + 64'(acc - m_edge);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // s1 = {msip,mtip,ssip} the cycle after acceptance, s2 = one cycle later
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int acc,
                     output logic [2:0] s1, output logic [2:0] s2);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_wstrb = ws;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid_after_accept", resp_valid, 1);
    s1 = {msip_o, mtip_o, ssip_o};
    rd = resp_data;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    s2 = {msip_o, mtip_o, ssip_o};
  endtask

  task automatic mt_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rd;
    int          acc;
    logic [2:0]  s1, s2;
    logic [63:0] v;
    bus(a, wd, ws, rd, acc, s1, s2);
    v = mt_now(acc + 1);
    for (int i = 0; i < 4; i++) begin
      if (ws[i]) begin
        if (a[2]) v[32 + 8*i +: 8] = wd[8*i +: 8];
        else      v[8*i +: 8]      = wd[8*i +: 8];
      end
    end
    m_val  = v;
    m_edge = acc + 1;
    chk("mtime_write_rdata", rd, 0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp_rd;
    logic        exp_msip;
    logic        exp_ssip;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r1, r2, held;
    int          acc, a1, a2, exp_rise;
    logic [2:0]  s1, s2;
    logic [63:0] mv;

    vecs[0]  = '{A_MSIP,        32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 1'b0};
    vecs[1]  = '{A_MSIP,        32'h0,         4'h0,    32'h1,         1'b1, 1'b0};
    vecs[2]  = '{A_MSIP,        32'h0,         4'hF,    32'h0,         1'b0, 1'b0};
    vecs[3]  = '{A_MSIP,        32'h0,         4'h0,    32'h0,         1'b0, 1'b0};
    vecs[4]  = '{A_MSIP,        32'h3,         4'b1110, 32'h0,         1'b0, 1'b0};
    vecs[5]  = '{A_SSIP,        32'h1,         4'b0001, 32'h0,         1'b0, 1'b1};
    vecs[6]  = '{A_SSIP,        32'h0,         4'h0,    32'h0,         1'b0, 1'b0};
    vecs[7]  = '{A_SSIP,        32'h1,         4'b0010, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{B + 32'h1234,  32'h0,         4'h0,    32'h0,         1'b0, 1'b0};
    vecs[9]  = '{B + 32'h1234,  32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0, 1'b0};
    vecs[10] = '{A_MSIP,        32'h1,         4'hF,    32'h0,         1'b1, 1'b0};
    vecs[11] = '{A_MSIP + 32'h3, 32'h0,        4'h0,    32'h1,         1'b1, 1'b0};
    vecs[12] = '{A_CMPLO,       32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1, 1'b0};
    vecs[13] = '{A_CMPLO,       32'h1234_5678, 4'b0110, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{A_CMPLO,       32'h0,         4'h0,    32'hFF34_56FF, 1'b1, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_irq_lines", {msip_o, mtip_o, ssip_o}, 0);
    rstn = 1'b1;
    m_val = 64'd0; m_edge = cyc;

    // free-running mtime, 10-cycle delta
    bus(A_MTLO, 0, 4'h0, r1, a1, s1, s2);
    chk("mtime_lo_first", r1, mt_now(a1) & 64'hFFFF_FFFF);
    repeat (7) @(negedge clk);
    bus(A_MTLO, 0, 4'h0, r2, a2, s1, s2);
    chk("mtime_delta_10", r2 - r1, 10);
    chk("mtip_idle", mtip_o, 0);

    // compare at 0x20
    mt_write(A_MTHI, 32'h0, 4'hF);
    mt_write(A_MTLO, 32'h0, 4'hF);
    bus(A_CMPLO, 32'h20, 4'hF, rd, acc, s1, s2);
    bus(A_CMPHI, 32'h0, 4'hF, rd, acc, s1, s2);
    chk("mtip_low_after_cmp", s1[1], 0);
    exp_rise = m_edge + 32'h20 - int'(m_val[31:0]);
    while (!mtip_o && cyc < exp_rise + 50) @(negedge clk);
    chk("mtip_rise_cycle", cyc, exp_rise);
    bus(A_CMPHI, 32'hFFFF_FFFF, 4'hF, rd, acc, s1, s2);
    chk("mtip_drop_after_cmp_hi", s1[1], 0);

    // wrap and byte-strobed mtime write
    mt_write(A_MTHI, 32'hFFFF_FFFF, 4'hF);
    mt_write(A_MTLO, 32'hFFFF_FFFE, 4'hF);
    bus(A_MTLO, 0, 4'h0, rd, acc, s1, s2);
    mv = mt_now(acc);
    chk("wrap_lo_model", rd, mv[31:0]);
    chk("wrap_lo_zero", rd, 0);
    bus(A_MTHI, 0, 4'h0, rd, acc, s1, s2);
    mv = mt_now(acc);
    chk("wrap_hi_zero", rd, mv[63:32]);
    mt_write(A_MTLO, 32'h0000_00AB, 4'b0001);
    bus(A_MTLO, 0, 4'h0, rd, acc, s1, s2);
    mv = mt_now(acc);
    chk("mtime_byte0_write", rd, mv[31:0]);

    // register table
    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].addr, vecs[i].wd, vecs[i].ws, rd, acc, s1, s2);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_msip", i), s1[2], vecs[i].exp_msip);
      chk($sformatf("vec%0d_ssip", i), s1[0], vecs[i].exp_ssip);
      chk($sformatf("vec%0d_ssip_next", i), s2[0], 0);
    end

    // backpressure: held response, second request waiting
    @(negedge clk);
    req_valid = 1'b1; req_addr = A_MSIP; req_wdata = 0; req_wstrb = 4'h0;
    @(negedge clk);
    held = resp_data;
    chk("bp_resp_valid", resp_valid, 1);
    chk("bp_held_data", held, 1);
    req_addr = A_MSIP; req_wdata = 32'h0; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_req_ready_%0d", i), req_ready, 0);
      chk($sformatf("bp_data_stable_%0d", i), resp_data, held);
    end
    chk("bp_msip_untouched", msip_o, 1);

    // reset mid-response
    #2 rstn = 1'b0;
    #1;
    req_valid = 1'b0;
    chk("mrst_resp_valid", resp_valid, 0);
    chk("mrst_req_ready", req_ready, 1);
    chk("mrst_resp_data", resp_data, 0);
    chk("mrst_irq_lines", {msip_o, mtip_o, ssip_o}, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_val = 64'd0; m_edge = cyc;
    repeat (3) @(negedge clk);
    chk("post_rst_no_resp", resp_valid, 0);
    bus(A_MSIP, 0, 4'h0, rd, acc, s1, s2);
    chk("post_rst_msip", rd, 0);
    bus(A_CMPLO, 0, 4'h0, rd, acc, s1, s2);
    chk("post_rst_cmp_lo", rd, 32'hFFFF_FFFF);
    bus(A_CMPHI, 0, 4'h0, rd, acc, s1, s2);
    chk("post_rst_cmp_hi", rd, 32'hFFFF_FFFF);
    bus(A_MTLO, 0, 4'h0, rd, acc, s1, s2);
    mv = mt_now(acc);
    chk("post_rst_mtime_lo", rd, mv[31:0]);
    bus(A_MTHI, 0, 4'h0, rd, acc, s1, s2);
    chk("post_rst_mtime_hi", rd, 0);
    chk("post_rst_mtip", mtip_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
